// File: rtl/add_share_arbiter.sv
// Round-robin share of one W-bit adder among NREQ requesters; response 2 cycles after grant, held while rsp_ready=0.
// Optional ADD_SHARE_ARB_STATS_EN adds saturating stat_ops / stat_stall counters.
module add_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_op1,
  input  logic [NREQ*W-1:0] req_op2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
`ifdef ADD_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_id;
  logic           win_vld;
  logic [W-1:0]   win_op1, win_op2;
  logic [W-1:0]   op1_q, op2_q;
  logic [IDW-1:0] id_q;
  logic [W:0]     sum_full;
  int             pos;

  // Scan priority positions rr_ptr, rr_ptr+1, ... and keep the first valid requester.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    pos     = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!win_vld && pos == i && req_valid[i]) begin
          win_vld = 1'b1;
          win_id  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    win_op1 = '0;
    win_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_op1 = req_op1[i*W +: W];
        win_op2 = req_op2[i*W +: W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = EXEC;
          for (int i = 0; i < NREQ; i++) req_ready[i] = (win_id == IDW'(i));
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sum_full  = {1'b0, op1_q} + {1'b0, op2_q};
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      id_q     <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_vld) begin
        op1_q  <= win_op1;
        op2_q  <= win_op2;
        id_q   <= win_id;
        rr_ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
      // Response register only loads in EXEC, so it is stable through RESP.
      if (state == EXEC) begin
        rsp_sum  <= sum_full[W-1:0];
        rsp_cout <= sum_full[W];
        rsp_id   <= id_q;
      end
    end
  end

`ifdef ADD_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else if (state == RESP) begin
      if (rsp_ready && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (!rsp_ready && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter; stats checks run when ADD_SHARE_ARB_STATS_EN is defined.
module tb_add_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_op1;
  logic [NREQ*W-1:0] req_op2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
`ifdef ADD_SHARE_ARB_STATS_EN
  logic [15:0]       stat_ops;
  logic [15:0]       stat_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  add_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ADD_SHARE_ARB_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_stall(stat_stall)
`endif
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]        = 1'b1;
    req_op1[i*W +: W]   = a;
    req_op2[i*W +: W]   = b;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy});
    end
`ifdef ADD_SHARE_ARB_STATS_EN
    total++;
    if ({stat_ops, stat_stall} !== 32'h0) begin
      bad++;
      $display("FAIL reset_stats got=%h exp=0", {stat_ops, stat_stall});
    end
`endif
    rst_n = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_req(2, 8'h12, 8'h34);
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL single_grant got=%b exp=0100", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    total++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL single_exec busy=%b rsp_valid=%b req_ready=%b exp 1 0 0000", busy, rsp_valid, req_ready);
    end
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46 || rsp_cout !== 1'b0 || rsp_id !== 2'd2) begin
      bad++;
      $display("FAIL single_rsp got v=%b sum=%h c=%b id=%0d exp v=1 sum=46 c=0 id=2", rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    step();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done rsp_valid=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] a  [3] = '{8'hFF, 8'h80, 8'hF0};
    logic [W-1:0] b  [3] = '{8'h01, 8'h80, 8'h0F};
    logic [W-1:0] es [3] = '{8'h00, 8'h00, 8'hFF};
    logic         ec [3] = '{1'b1, 1'b1, 1'b0};
    rsp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      set_req(3, a[t], b[t]);
      step();
      req_valid = '0;
      step();
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== es[t] || rsp_cout !== ec[t] || rsp_id !== 2'd3) begin
        bad++;
        $display("FAIL carry_%0d got v=%b sum=%h c=%b id=%0d exp v=1 sum=%h c=%b id=3",
                 t, rsp_valid, rsp_sum, rsp_cout, rsp_id, es[t], ec[t]);
      end
      step();
    end
  endtask

  task automatic test_fairness();
    logic [W-1:0] a  [8] = '{8'h01, 8'h10, 8'h7F, 8'hFE, 8'h55, 8'h80, 8'h33, 8'hC0};
    logic [W-1:0] b  [8] = '{8'h02, 8'h20, 8'h01, 8'h03, 8'hAA, 8'h81, 8'h44, 8'h40};
    logic [W-1:0] es [8] = '{8'h03, 8'h30, 8'h80, 8'h01, 8'hFF, 8'h01, 8'h77, 8'h00};
    logic         ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [NREQ-1:0] exp_rdy;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, a[i], b[i]);
    for (int t = 0; t < 8; t++) begin
      exp_rdy = 4'b0001 << (t % 4);
      #1;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL fair_grant_%0d got=%b exp=%b", t, req_ready, exp_rdy);
      end
      step();
      if (t < 4) set_req(t, a[t+4], b[t+4]);
      else req_valid[t % 4] = 1'b0;
      step();
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== es[t] || rsp_cout !== ec[t] || rsp_id !== IDW'(t % 4)) begin
        bad++;
        $display("FAIL fair_rsp_%0d got v=%b sum=%h c=%b id=%0d exp v=1 sum=%h c=%b id=%0d",
                 t, rsp_valid, rsp_sum, rsp_cout, rsp_id, es[t], ec[t], t % 4);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(1, 8'h20, 8'h22);
    step();
    req_valid[1] = 1'b0;
    set_req(3, 8'h05, 8'h06);
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'h42 || rsp_id !== 2'd1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_%0d got v=%b sum=%h id=%0d rdy=%b busy=%b exp v=1 sum=42 id=1 rdy=0000 busy=1",
                 c, rsp_valid, rsp_sum, rsp_id, req_ready, busy);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL bp_handshake_rdy got=%b exp=0000", req_ready);
    end
    step();
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL bp_idle got v=%b rdy=%b exp v=0 rdy=1000", rsp_valid, req_ready);
    end
    step();
    req_valid = '0;
    step();
    total++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 8'h0B || rsp_id !== 2'd3) begin
      bad++;
      $display("FAIL bp_pending_rsp got v=%b sum=%h id=%0d exp v=1 sum=0b id=3", rsp_valid, rsp_sum, rsp_id);
    end
    step();
  endtask

  task automatic test_async_reset();
    rsp_ready = 1'b1;
    set_req(2, 8'h11, 8'h22);
    step();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=0", {req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle v=%b busy=%b exp 0 0", rsp_valid, busy);
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h01, 8'h01);
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL post_reset_grant got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    step();
  endtask

`ifdef ADD_SHARE_ARB_STATS_EN
  task automatic test_stats();
    for (int t = 0; t < 3; t++) begin
      rsp_ready = 1'b1;
      set_req(0, 8'h01, 8'h02);
      step();
      req_valid = '0;
      if (t == 2) rsp_ready = 1'b0;
      step();
      repeat ((t == 2) ? 4 : 0) step();
      rsp_ready = 1'b1;
      step();
    end
    total++;
    if (stat_ops !== 16'd3 || stat_stall !== 16'd4) begin
      bad++;
      $display("FAIL stats got ops=%0d stall=%0d exp ops=3 stall=4", stat_ops, stat_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_fairness();
    test_backpressure();
    test_async_reset();
`ifdef ADD_SHARE_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one W-bit add unit between NREQ requesters.
- Round-robin arbitration; valid/ready handshake on each request port and on a single shared response port.
- Operands are registered at grant. The sum is computed from the registered operands and held in a response register until consumed.
- Sits between the crossbar request ports and the shared adder datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand/sum width.
- IDW, 2, response id width; must equal ceil(log2(NREQ)), minimum 1.

Ports:
- clk  input  1  rising-edge clock, sole clock of the block.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit set.
- req_op1  input  NREQ*W  packed operand 1; requester i uses bits [i*W +: W].
- req_op2  input  NREQ*W  packed operand 2, same packing as req_op1.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_sum  output  W  (op1+op2) mod 2^W.
- rsp_cout  output  1  carry out of bit W-1.
- rsp_id  output  IDW  index of the requester served.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; rr_ptr=0; req_ready=0; rsp_valid=0; rsp_sum=0; rsp_cout=0; rsp_id=0; busy=0. Operand registers clear to 0.
- Reset mid-operation discards any in-flight request or response; nothing is replayed after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - Transfer occurs on req_valid[i] & req_ready[i] at the clock edge. On transfer: latch op1/op2/id, go to EXEC, set rr_ptr=(winner+1) mod NREQ.
  - No valid requests: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - Register {cout,sum} = op1+op2 computed at W+1 bits.
  - Set rsp_valid=1 and go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum/rsp_cout/rsp_id stable until handshake.
  - On rsp_ready=1: rsp_valid drops next cycle; return to IDLE.
  - While rsp_ready=0: hold all response outputs.
- Latency: request accepted at edge N → rsp_valid high in the cycle after edge N+1. Minimum initiation interval is 3 cycles per request (accept, exec, resp with rsp_ready=1).
- Requester rules:
  - A requester must hold valid and operands stable until accepted.
  - Deasserting valid before acceptance is allowed (no transfer occurs).
  - The arbiter never grants a requester whose valid is low.
- Starvation freedom: a continuously valid requester is granted within NREQ grants.
- Wrap-around cases:
  - rr_ptr wraps from NREQ-1 to 0.
  - Sum wraps modulo 2^W, with the carry reported on rsp_cout.
- Simultaneous events:
  - All requesters valid: grants rotate 0,1,2,...,NREQ-1,0.
  - rsp_ready asserted in the first RESP cycle: the response is consumed in that cycle.
  - No new grant is issued in the same cycle as a response handshake; the next grant happens in IDLE one cycle later.

Optional Feature:
- Macro: ADD_SHARE_ARB_STATS_EN.
- When defined, the block adds two outputs:
  - stat_ops (16 bits): saturating count of completed response handshakes.
  - stat_stall (16 bits): saturating count of cycles in RESP with rsp_ready=0.
- Both counters reset to 0 on rst_n low and saturate at 0xFFFF.
- When not defined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Single request, all else idle: requester 2 sends op1=0x12, op2=0x34, rsp_ready=1 → rsp_valid one cycle after EXEC; rsp_sum=0x46, rsp_cout=0, rsp_id=2; busy returns to 0 after the handshake.
- Carry/wrap: op1=0xFF, op2=0x01 → rsp_sum=0x00, rsp_cout=1. Then op1=0x80, op2=0x80 → rsp_sum=0x00, rsp_cout=1. Then op1=0xF0, op2=0x0F → rsp_sum=0xFF, rsp_cout=0.
- Fairness: all 4 requesters valid continuously for 8 transactions with distinct operands → rsp_id sequence 0,1,2,3,0,1,2,3, and each sum matches its own operands.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_sum, rsp_id stable; all req_ready=0. The pending requester is accepted only after the handshake plus one IDLE cycle.
- Async reset mid-EXEC: drop rst_n between edges → outputs zero immediately, without waiting for a clock edge. After release with no requests, rsp_valid stays 0 and the first grant goes to requester 0.
- With ADD_SHARE_ARB_STATS_EN: 3 transactions plus 4 stall cycles → stat_ops=3, stat_stall=4.
